// File: rtl/fsm_counter_run.sv
// Counting worker for the IDLE/RUN/DONE handshake: an accepted run request
// latches N, the block stays in RUN for exactly N cycles, then pulses done once.
module fsm_counter_run #(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
    input  logic                 i_abort,
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_last;
    logic                 accept;

    assign cnt_last = num_q - CNT_ONE;
    assign accept   = i_run && !i_abort;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        num_d   = num_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (i_num_cnt != '0) begin
                        num_d   = i_num_cnt;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Abort takes priority over reaching the final count.
                if (i_abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end

    assign o_idle    = (state_q == S_IDLE);
    assign o_running = (state_q == S_RUN);
    assign o_done    = (state_q == S_DONE);
    assign o_err     = err_q;
    assign o_cnt     = cnt_q;

endmodule

// File: doc/fsm_counter_run.md
# fsm_counter_run

Counting worker that drives the team's IDLE/RUN/DONE control handshake with a real completion condition. On an accepted run request it latches a cycle count N, spends exactly N cycles in RUN, and pulses done for one cycle in DONE. It then returns to IDLE. It sits directly downstream of the run/done controller and supplies the `is_done` condition that the controller currently hard-wires high.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- Parameters:
  - `CNT_WIDTH`, default 7: width of the count request and of the counter.
- Ports:
  - `clk`  in  1  rising-edge clock.
  - `reset`  in  1  synchronous reset, active-high.
  - `i_run`  in  1  run request; sampled only in IDLE.
  - `i_num_cnt`  in  CNT_WIDTH  requested cycle count N; captured with an accepted `i_run`.
  - `i_abort`  in  1  cancel request; acts in IDLE and RUN.
  - `o_idle`  out  1  high while state is IDLE.
  - `o_running`  out  1  high while state is RUN.
  - `o_done`  out  1  high for the single DONE cycle.
  - `o_err`  out  1  one-cycle pulse when a run request is rejected for N=0.
  - `o_cnt`  out  CNT_WIDTH  current count value, registered.

## Operation
- States: S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10. Encoding 2'b11 is illegal and recovers to S_IDLE on the next edge.
- State, counter, latched N and `o_err` are registers.
  - `o_idle`, `o_running` and `o_done` are Moore decodes of the state register only.
  - The next-state logic defaults to S_IDLE so that no latches are inferred.
- S_IDLE:
  - `i_abort`=1: stay in IDLE and ignore `i_run`.
  - `i_run`=1, `i_abort`=0 and `i_num_cnt`!=0: latch N, clear `o_cnt` to 0, go to S_RUN.
  - `i_run`=1, `i_abort`=0 and `i_num_cnt`==0: stay in IDLE and set `o_err`=1 for one cycle.
  - Otherwise: stay in IDLE.
- S_RUN:
  - `i_abort`=1: go to S_IDLE and clear `o_cnt`. No DONE is produced. Abort wins over completion on the same edge.
  - Else if `o_cnt` == N-1: go to S_DONE and hold `o_cnt` at N-1.
  - Else: increment `o_cnt` by 1.
- S_DONE: go unconditionally to S_IDLE and clear `o_cnt`. `i_run` and `i_abort` are ignored.
- Ignored inputs:
  - `i_run` in RUN or DONE is dropped. It is not queued.
  - Changes on `i_num_cnt` after acceptance have no effect.
- Arithmetic:
  - N ranges over 1..2^CNT_WIDTH-1 (127 by default).
  - The counter never exceeds N-1, so no wrap-around is possible.
  - The N-1 compare is done at CNT_WIDTH bits.

## Timing
- Reset values (the edge with `reset`=1 overrides everything):
  - State S_IDLE; `o_cnt`=0; latched N=0; `o_err`=0.
  - Outputs therefore read `o_idle`=1, `o_running`=0, `o_done`=0.
- Run sequence: let E0 be the edge that accepts `i_run`.
  - After E0: RUN with `o_cnt`=0.
  - After E0+k, for k < N: RUN with `o_cnt`=k.
  - After E0+N: DONE.
  - After E0+N+1: IDLE.
  - `o_running` is high for exactly N cycles. `o_done` is high for exactly 1 cycle.
- Earliest back-to-back: a new `i_run` can be accepted on the edge leaving IDLE, which is E0+N+2. Total turnaround is N+2 cycles.
- `o_err` is high in the cycle after the rejecting edge and low on the following edge unless rejected again.
- Reset asserted mid-RUN or in DONE: on that edge return to reset values, with no `o_done` pulse.

## Test plan
- Reset, then hold `reset`=1 for 3 cycles -> `o_idle`=1, `o_cnt`=0, `o_done`=0 throughout.
- `i_run`=1 with `i_num_cnt`=5 for one cycle -> `o_running` high for 5 cycles with `o_cnt` 0,1,2,3,4; `o_done` high for 1 cycle; then `o_idle`=1.
- `i_num_cnt`=0 with `i_run`=1 -> no RUN; `o_err`=1 for one cycle; `o_idle` stays 1.
- N=10, `i_abort` pulsed when `o_cnt`=3 -> IDLE next cycle, `o_cnt`=0, `o_done` never asserts.
- N=4, `i_abort` coincident with `o_cnt`=3 -> IDLE, no DONE; separately `i_run` held high throughout a run -> second run starts exactly N+2 cycles after the first acceptance.
- N=127 (max) -> 127 RUN cycles, last `o_cnt`=126, then one DONE cycle; `reset` asserted during a second run at `o_cnt`=50 -> IDLE next cycle with no `o_done`.
